// File: rtl/mm_stream_pkg.sv
// Shared definitions for the line prefetch stream: FSM states, default
// widths and the Game Boy screen geometry the block was first sized for.
package mm_stream_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 23;

  localparam int GB_LINE_PIXELS = 160;
  localparam int GB_NUM_LINES   = 144;
  localparam int GB_LINE_STRIDE = 320;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    READY,
    DRAIN
  } stream_state_t;

  // Counter width helper that never collapses to zero bits for depth 1.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/mm_pingpong_ram.sv
// Two-bank line buffer. The fill side writes one bank while the scan-out side
// reads the other; the read port is registered (1-cycle latency).
// The word index is {bank, ptr}; with a non-power-of-two line depth the top
// words of each bank are simply never addressed.
module mm_pingpong_ram
  import mm_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PTR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(2**(PTR_W+1))-1];

  // Write port: buffer contents carry no reset, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_ptr}] <= wr_data;
    end
  end

  // Registered read port; output register clears so the pixel bus idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_ptr}];
    end
  end

endmodule

// File: rtl/mm_line_prefetch_stream.sv
// Line prefetcher: fetches one video line per PSRAM burst into a ping-pong
// buffer and serves pixels to scan-out with 1-cycle latency.
// Optional build macro MM_LINE_REPEAT_EN: every fetched line is shown twice
// (2x vertical scale); only every second xLineEnd promotes a new line.
module mm_line_prefetch_stream
  import mm_stream_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                LINE_DEPTH  = GB_LINE_PIXELS,
  parameter int                NUM_LINES   = GB_NUM_LINES,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                LINE_STRIDE = GB_LINE_STRIDE
) (
  input  logic              xClk,
  input  logic              xRstN,
  input  logic              xFrameStart,
  input  logic              xLineEnd,
  input  logic              xRamReady,
  output logic              oRdReq,
  input  logic              iRdAck,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic              iRdValid,
  input  logic [DATA_W-1:0] iRdData,
  input  logic              iPixRd,
  output logic [DATA_W-1:0] oPixData,
  output logic              oPixValid,
  output logic              oUnderrun,
  output logic              oOverrun
);

  localparam int PTR_W  = clog2_min1(LINE_DEPTH);
  localparam int LINE_W = clog2_min1(NUM_LINES + 1);
  localparam logic [PTR_W-1:0]  LAST_BEAT = PTR_W'(LINE_DEPTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

  stream_state_t     state, state_next;
  logic [LINE_W-1:0] line, line_next;
  logic              fill_bank, fill_bank_next;
  logic              disp_bank, disp_bank_next;
  logic [PTR_W-1:0]  beat_cnt, beat_cnt_next;
  logic              pend_le, pend_le_next;
  logic              underrun, underrun_next;
  logic              overrun, overrun_next;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pix_valid;
  logic              wr_en;
  logic              promote;
  logic              restart;
  logic              le_promote;
  logic              rd_expected;

`ifdef MM_LINE_REPEAT_EN
  logic rep_phase;

  assign le_promote = xLineEnd && !rep_phase;

  // After a promotion the next line end is only a repeat of the same line.
  always_ff @(posedge xClk or negedge xRstN) begin
    if (!xRstN) begin
      rep_phase <= 1'b0;
    end else if (xFrameStart) begin
      rep_phase <= 1'b0;
    end else if (promote) begin
      rep_phase <= 1'b1;
    end else if (xLineEnd) begin
      rep_phase <= 1'b0;
    end
  end
`else
  assign le_promote = xLineEnd;
`endif

  assign rd_expected = (state == FILL) || (state == DRAIN) ||
                       ((state == REQ) && iRdAck);

  // Burst request is a level held for the whole REQ state; address is
  // derived from the line counter, which cannot change while requesting.
  assign oRdReq  = (state == REQ);
  assign oRdAddr = (state == REQ) ?
                   (BASE_ADDR + (ADDR_W'(line) * ADDR_W'(LINE_STRIDE))) : '0;

  assign oUnderrun = underrun;
  assign oOverrun  = overrun;
  assign oPixValid = pix_valid;

  // State register for the fetch FSM and its bookkeeping.
  always_ff @(posedge xClk or negedge xRstN) begin
    if (!xRstN) begin
      state     <= IDLE;
      line      <= '0;
      fill_bank <= 1'b0;
      disp_bank <= 1'b0;
      beat_cnt  <= '0;
      pend_le   <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      line      <= line_next;
      fill_bank <= fill_bank_next;
      disp_bank <= disp_bank_next;
      beat_cnt  <= beat_cnt_next;
      pend_le   <= pend_le_next;
      underrun  <= underrun_next;
      overrun   <= overrun_next;
    end
  end

  // Next-state logic: per-state decisions first, then the shared beat,
  // promotion and restart actions; restart is last so a frame start wins.
  always_comb begin
    state_next     = state;
    line_next      = line;
    fill_bank_next = fill_bank;
    disp_bank_next = disp_bank;
    beat_cnt_next  = beat_cnt;
    pend_le_next   = pend_le;
    underrun_next  = underrun;
    overrun_next   = overrun;
    wr_en          = 1'b0;
    promote        = 1'b0;
    restart        = 1'b0;

    case (state)
      IDLE: begin
        if (xFrameStart && xRamReady) begin
          restart = 1'b1;
        end
      end
      REQ: begin
        if (xFrameStart) begin
          restart = 1'b1;
        end else begin
          if (le_promote) begin
            underrun_next = 1'b1;
            pend_le_next  = 1'b1;
          end
          if (iRdAck) begin
            state_next = FILL;
            wr_en      = iRdValid;
          end
        end
      end
      FILL: begin
        if (xFrameStart) begin
          if (iRdValid && (beat_cnt == LAST_BEAT)) begin
            restart = 1'b1;
          end else begin
            state_next    = DRAIN;
            beat_cnt_next = beat_cnt + PTR_W'(iRdValid);
          end
        end else begin
          if (le_promote) begin
            underrun_next = 1'b1;
            pend_le_next  = 1'b1;
          end
          wr_en = iRdValid;
        end
      end
      READY: begin
        if (xFrameStart) begin
          restart = 1'b1;
        end else if (le_promote || pend_le) begin
          promote = 1'b1;
        end
      end
      DRAIN: begin
        if (iRdValid) begin
          if (beat_cnt == LAST_BEAT) begin
            restart = 1'b1;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (wr_en) begin
      if (beat_cnt == LAST_BEAT) begin
        state_next    = READY;
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt + 1'b1;
      end
    end

    if (promote) begin
      disp_bank_next = fill_bank;
      fill_bank_next = ~fill_bank;
      line_next      = line + 1'b1;
      beat_cnt_next  = '0;
      pend_le_next   = 1'b0;
      state_next     = (line == LAST_LINE) ? IDLE : REQ;
    end

    if (restart) begin
      line_next      = '0;
      fill_bank_next = 1'b0;
      beat_cnt_next  = '0;
      pend_le_next   = 1'b0;
      state_next     = REQ;
    end

    if (xFrameStart) begin
      underrun_next = 1'b0;
      overrun_next  = 1'b0;
      pend_le_next  = 1'b0;
    end

    if (iRdValid && !rd_expected) begin
      overrun_next = 1'b1;
    end
  end

  // Scan-out read pointer: saturates on the last pixel, rewinds each line.
  always_ff @(posedge xClk or negedge xRstN) begin
    if (!xRstN) begin
      rd_ptr    <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= iPixRd;
      if (xFrameStart || xLineEnd) begin
        rd_ptr <= '0;
      end else if (iPixRd && (rd_ptr != LAST_BEAT)) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  mm_pingpong_ram #(
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (xClk),
    .rst_n   (xRstN),
    .wr_en   (wr_en),
    .wr_bank (fill_bank),
    .wr_ptr  (beat_cnt),
    .wr_data (iRdData),
    .rd_en   (iPixRd),
    .rd_bank (disp_bank),
    .rd_ptr  (rd_ptr),
    .rd_data (oPixData)
  );

endmodule
